dds_config_sequencer: RTL and testbench

Sequences the DDS (AD9833-class) configuration over a 3-wire serial bus (FSYNC/SCLK/SDATA) from the I2C-written DDS register values. On an apply request it snapshots the five configuration words and shifts them out MSB-first in a fixed order. Sits between the I2C slave register file and the DDS device pins, in the SYS_CLK domain.

---
 rtl/dds_cfg_pkg.sv | 26 ++
 rtl/dds_config_sequencer_spi_shifter.sv | 69 ++++++
 rtl/dds_config_sequencer.sv | 165 ++++++++++++++++
 tb/tb_dds_config_sequencer.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dds_cfg_pkg.sv
// Shared types and constants for the DDS configuration sequencer.
package dds_cfg_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        SHIFT = 3'd2,
        GAP   = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Serial word width on the DDS bus; the device only accepts 16-bit words.
    localparam int WORD_W    = 16;
    localparam int NUM_WORDS = 5;

    // Fixed transmit order of the configuration words.
    localparam logic [2:0] W_CTRL     = 3'd0;
    localparam logic [2:0] W_FREQ_LSB = 3'd1;
    localparam logic [2:0] W_FREQ_MSB = 3'd2;
    localparam logic [2:0] W_PHASE    = 3'd3;
    localparam logic [2:0] W_EXIT     = 3'd4;

    // The control byte occupies word0[15:8]; its bit 0 lands on the device RESET bit.
    localparam int DDS_RESET_BIT = 8;

endpackage

// File: rtl/dds_config_sequencer_spi_shifter.sv
// Shifts one 16-bit word MSB-first onto the DDS 3-wire bus.
// A start pulse loads the word and drops FSYNC; word_done flags the last SYS_CLK
// cycle of bit 0's low phase so the caller can change state on the same edge
// that FSYNC returns high.
module dds_spi_shifter
    import dds_cfg_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic              SYS_CLK,
    input  logic              start_rst,
    input  logic              start,
    input  logic [WORD_W-1:0] word,
    output logic              fsync,
    output logic              sclk,
    output logic              sdata,
    output logic              word_done
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam int BIT_W = $clog2(WORD_W);

    logic [DIV_W-1:0]  div_cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic [WORD_W-1:0] shreg;

    // FSYNC low means a word is in flight, so it doubles as the active flag.
    assign word_done = !fsync && !sclk && (bit_cnt == '0) && (div_cnt == DIV_LAST);

    // Half-period divider, bit counter and shift register; sdata changes only
    // at the start of a high phase so it is stable across the falling edge.
    always_ff @(posedge SYS_CLK or posedge start_rst) begin
        if (start_rst) begin
            fsync   <= 1'b1;
            sclk    <= 1'b1;
            sdata   <= 1'b0;
            div_cnt <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
        end else if (start) begin
            fsync   <= 1'b0;
            sclk    <= 1'b1;
            sdata   <= word[WORD_W-1];
            div_cnt <= '0;
            bit_cnt <= BIT_W'(WORD_W - 1);
            shreg   <= word;
        end else if (!fsync) begin
            if (div_cnt == DIV_LAST) begin
                div_cnt <= '0;
                if (sclk) begin
                    sclk <= 1'b0;
                end else if (bit_cnt == '0) begin
                    fsync <= 1'b1;
                    sclk  <= 1'b1;
                    sdata <= 1'b0;
                end else begin
                    bit_cnt <= bit_cnt - 1'b1;
                    sclk    <= 1'b1;
                    sdata   <= shreg[WORD_W-2];
                    shreg   <= {shreg[WORD_W-2:0], 1'b0};
                end
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/dds_config_sequencer.sv
// Sends the five DDS configuration words over the 3-wire bus on each rising
// edge of apply_async, using a snapshot taken at the start of the sequence.
module dds_config_sequencer
    import dds_cfg_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 2
) (
    input  logic        SYS_CLK,
    input  logic        start_rst,
    input  logic        apply_async,
    input  logic [7:0]  dds_control_reg,
    input  logic [15:0] dds_frequency_reg0_LSB,
    input  logic [15:0] dds_frequency_reg0_MSB,
    input  logic [15:0] dds_phase_reg0,
    input  logic [15:0] dds_exit_reset,
    output logic        dds_fsync,
    output logic        dds_sclk,
    output logic        dds_sdata,
    output logic        busy,
    output logic        done,
    output logic [2:0]  word_idx
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [2:0] LAST_WORD = 3'(NUM_WORDS - 1);

    logic              s1, s2, s2_d;
    logic              apply_pulse;
    state_t            state;
    logic              pending;
    logic [GAP_W-1:0]  gap_cnt;
    logic [WORD_W-1:0] shadow [NUM_WORDS];
    logic [WORD_W-1:0] ctrl_word;
    logic [WORD_W-1:0] shift_word;
    logic              shift_start;
    logic              word_done;

    assign ctrl_word   = {dds_control_reg, {DDS_RESET_BIT{1'b0}}};
    assign apply_pulse = s2 & ~s2_d;

    // Bring the apply level into SYS_CLK and detect its rising edge.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge SYS_CLK or posedge start_rst) begin
        if (start_rst) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            s2_d <= 1'b0;
        end else begin
            s1   <= apply_async;
            s2   <= s1;
            s2_d <= s2;
        end
    end

    // Capture all five words in LOAD so later register writes cannot tear a sequence.
    // NOTE: the shadow array has no reset; it is always written in LOAD before it is read.
    always_ff @(posedge SYS_CLK) begin
        if (state == LOAD) begin
            shadow[W_CTRL]     <= ctrl_word;
            shadow[W_FREQ_LSB] <= dds_frequency_reg0_LSB;
            shadow[W_FREQ_MSB] <= dds_frequency_reg0_MSB;
            shadow[W_PHASE]    <= dds_phase_reg0;
            shadow[W_EXIT]     <= dds_exit_reset;
        end
    end

    // Select the word to launch: word 0 goes out on the same edge the snapshot is
    // taken, so it comes straight from the inputs; later words come from the shadow.
    // NOTE: every output gets a default first so no latch is inferred.
    always_comb begin
        shift_word  = '0;
        shift_start = 1'b0;
        if (state == LOAD) begin
            shift_word  = ctrl_word;
            shift_start = 1'b1;
        end else if (state == GAP && gap_cnt == GAP_LAST && word_idx != LAST_WORD) begin
            shift_start = 1'b1;
            case (word_idx)
                W_CTRL:     shift_word = shadow[W_FREQ_LSB];
                W_FREQ_LSB: shift_word = shadow[W_FREQ_MSB];
                W_FREQ_MSB: shift_word = shadow[W_PHASE];
                default:    shift_word = shadow[W_EXIT];
            endcase
        end
    end

    // Sequence FSM with pending-apply tracking, gap timing and registered status.
    always_ff @(posedge SYS_CLK or posedge start_rst) begin
        if (start_rst) begin
            state    <= IDLE;
            pending  <= 1'b0;
            gap_cnt  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            word_idx <= '0;
        end else begin
            done <= 1'b0;
            if (apply_pulse && state != IDLE) begin
                pending <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (apply_pulse || pending) begin
                        state    <= LOAD;
                        pending  <= 1'b0;
                        busy     <= 1'b1;
                        word_idx <= W_CTRL;
                    end
                end
                LOAD: begin
                    state <= SHIFT;
                end
                SHIFT: begin
                    if (word_done) begin
                        state   <= GAP;
                        gap_cnt <= '0;
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        if (word_idx != LAST_WORD) begin
                            word_idx <= word_idx + 3'd1;
                            state    <= SHIFT;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                DONE: begin
                    word_idx <= W_CTRL;
                    if (pending || apply_pulse) begin
                        state   <= LOAD;
                        pending <= 1'b0;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    dds_spi_shifter #(
        .CLK_DIV (CLK_DIV)
    ) u_shifter (
        .SYS_CLK   (SYS_CLK),
        .start_rst (start_rst),
        .start     (shift_start),
        .word      (shift_word),
        .fsync     (dds_fsync),
        .sclk      (dds_sclk),
        .sdata     (dds_sdata),
        .word_done (word_done)
    );

endmodule

// File: tb/tb_dds_config_sequencer.sv
// Directed bench for dds_config_sequencer at CLK_DIV=4, GAP_CYCLES=2.
// A passive monitor samples the bus on the falling SYS_CLK edge and records
// frames, SCLK/FSYNC run lengths, busy run lengths and done pulses.
module tb_dds_config_sequencer;

    logic        SYS_CLK = 1'b0;
    logic        start_rst;
    logic        apply_async;
    logic [7:0]  dds_control_reg;
    logic [15:0] dds_frequency_reg0_LSB;
    logic [15:0] dds_frequency_reg0_MSB;
    logic [15:0] dds_phase_reg0;
    logic [15:0] dds_exit_reset;
    logic        dds_fsync;
    logic        dds_sclk;
    logic        dds_sdata;
    logic        busy;
    logic        done;
    logic [2:0]  word_idx;

    int n_cmp = 0;
    int n_bad = 0;

    // Monitor records
    logic [15:0] frame_q[$];
    int          edge_q[$];
    int          hi_q[$];
    int          lo_q[$];
    int          gap_q[$];
    int          busy_q[$];
    int          done_q[$];
    int          cyc = 0;

    dds_config_sequencer #(
        .CLK_DIV    (4),
        .GAP_CYCLES (2)
    ) dut (
        .SYS_CLK                (SYS_CLK),
        .start_rst              (start_rst),
        .apply_async            (apply_async),
        .dds_control_reg        (dds_control_reg),
        .dds_frequency_reg0_LSB (dds_frequency_reg0_LSB),
        .dds_frequency_reg0_MSB (dds_frequency_reg0_MSB),
        .dds_phase_reg0         (dds_phase_reg0),
        .dds_exit_reset         (dds_exit_reset),
        .dds_fsync              (dds_fsync),
        .dds_sclk               (dds_sclk),
        .dds_sdata              (dds_sdata),
        .busy                   (busy),
        .done                   (done),
        .word_idx               (word_idx)
    );

    always #5 SYS_CLK = ~SYS_CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Bus monitor, sampling mid-cycle.
    initial begin : monitor
        logic        p_sclk;
        logic        p_fsync;
        logic        p_busy;
        logic [15:0] sh;
        int          edges;
        int          sclk_run;
        int          fs_hi_run;
        int          busy_run;
        p_sclk = 1'b1; p_fsync = 1'b1; p_busy = 1'b0;
        sh = '0; edges = 0; sclk_run = 0; fs_hi_run = 0; busy_run = 0;
        forever begin
            @(negedge SYS_CLK);
            cyc++;
            if (!dds_fsync && p_fsync) begin
                if (word_idx != 3'd0) gap_q.push_back(fs_hi_run);
                sh = '0;
                edges = 0;
                sclk_run = 1;
            end else if (!dds_fsync) begin
                if (dds_sclk != p_sclk) begin
                    if (p_sclk) hi_q.push_back(sclk_run);
                    else        lo_q.push_back(sclk_run);
                    sclk_run = 1;
                end else begin
                    sclk_run++;
                end
                if (p_sclk && !dds_sclk) begin
                    sh = {sh[14:0], dds_sdata};
                    edges++;
                end
            end else if (!p_fsync) begin
                if (!p_sclk) lo_q.push_back(sclk_run);
                frame_q.push_back(sh);
                edge_q.push_back(edges);
            end
            if (dds_fsync) fs_hi_run = p_fsync ? fs_hi_run + 1 : 1;
            if (busy) busy_run = p_busy ? busy_run + 1 : 1;
            else if (p_busy) busy_q.push_back(busy_run);
            if (done) done_q.push_back(cyc);
            p_sclk = dds_sclk;
            p_fsync = dds_fsync;
            p_busy = busy;
        end
    end

    task automatic wait_done(input string tag, input int target, input int budget);
        int n = 0;
        while (done_q.size() < target && n < budget) begin
            @(negedge SYS_CLK);
            n++;
        end
        check(tag, 32'(done_q.size() >= target), 32'd1);
    endtask

    task automatic check_seq(input string tag, input int base,
                             input logic [15:0] w0, input logic [15:0] w1,
                             input logic [15:0] w2, input logic [15:0] w3,
                             input logic [15:0] w4);
        logic [15:0] exp [5];
        exp[0] = w0; exp[1] = w1; exp[2] = w2; exp[3] = w3; exp[4] = w4;
        check($sformatf("%s_frames", tag), 32'(frame_q.size() >= base + 5), 32'd1);
        if (frame_q.size() >= base + 5) begin
            for (int i = 0; i < 5; i++) begin
                check($sformatf("%s_word%0d", tag, i), 32'(frame_q[base+i]), 32'(exp[i]));
                check($sformatf("%s_edges%0d", tag, i), 32'(edge_q[base+i]), 32'd16);
            end
        end
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not end, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int fb, db, bb, bad_fs, bad_sc, bad_sd, bad_bz, n;
        start_rst = 1'b1;
        apply_async = 1'b0;
        dds_control_reg = 8'h21;
        dds_frequency_reg0_LSB = 16'h50C7;
        dds_frequency_reg0_MSB = 16'h4000;
        dds_phase_reg0 = 16'hC000;
        dds_exit_reset = 16'h2000;

        // Reset and idle
        repeat (5) @(posedge SYS_CLK);
        @(negedge SYS_CLK);
        start_rst = 1'b0;
        bad_fs = 0; bad_sc = 0; bad_sd = 0; bad_bz = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge SYS_CLK);
            if (dds_fsync !== 1'b1) bad_fs++;
            if (dds_sclk  !== 1'b1) bad_sc++;
            if (dds_sdata !== 1'b0) bad_sd++;
            if (busy      !== 1'b0) bad_bz++;
        end
        check("idle_fsync_bad", 32'(bad_fs), 0);
        check("idle_sclk_bad", 32'(bad_sc), 0);
        check("idle_sdata_bad", 32'(bad_sd), 0);
        check("idle_busy_bad", 32'(bad_bz), 0);
        check("idle_word_idx", 32'(word_idx), 0);
        check("idle_done", 32'(done), 0);

        // Basic sequence with latency and snapshot checks
        fb = frame_q.size(); db = done_q.size(); bb = busy_q.size();
        apply_async = 1'b1;
        @(posedge SYS_CLK);
        @(posedge SYS_CLK); #1;
        check("lat_e2_busy", 32'(busy), 0);
        @(posedge SYS_CLK); #1;
        check("lat_e3_busy", 32'(busy), 1);
        check("lat_e3_fsync", 32'(dds_fsync), 1);
        @(posedge SYS_CLK); #1;
        check("lat_e4_fsync", 32'(dds_fsync), 0);
        check("lat_e4_sclk", 32'(dds_sclk), 1);
        check("lat_e4_sdata", 32'(dds_sdata), 0);
        repeat (20) @(negedge SYS_CLK);
        check("snap_word_idx", 32'(word_idx), 0);
        dds_frequency_reg0_LSB = 16'hFFFF;
        wait_done("basic_done_seen", db + 1, 1000);
        repeat (5) @(negedge SYS_CLK);
        apply_async = 1'b0;
        check_seq("basic", fb, 16'h2100, 16'h50C7, 16'h4000, 16'hC000, 16'h2000);
        check("basic_done_count", 32'(done_q.size() - db), 1);
        check("basic_busy_runs", 32'(busy_q.size() - bb), 1);
        if (busy_q.size() > bb) check("basic_busy_len", 32'(busy_q[bb]), 652);
        check("basic_hi_count", 32'(hi_q.size()), 80);
        check("basic_lo_count", 32'(lo_q.size()), 80);
        n = 0;
        foreach (hi_q[i]) if (hi_q[i] != 4) n++;
        foreach (lo_q[i]) if (lo_q[i] != 4) n++;
        check("basic_sclk_phase_bad", 32'(n), 0);
        check("basic_gap_count", 32'(gap_q.size()), 4);
        n = 0;
        foreach (gap_q[i]) if (gap_q[i] != 2) n++;
        check("basic_gap_len_bad", 32'(n), 0);
        check("basic_end_busy", 32'(busy), 0);

        // Pending: three rises during a sequence collapse into one rerun
        repeat (10) @(negedge SYS_CLK);
        fb = frame_q.size(); db = done_q.size(); bb = busy_q.size();
        apply_async = 1'b1;
        repeat (30) @(negedge SYS_CLK);
        dds_phase_reg0 = 16'h1234;
        for (int k = 0; k < 3; k++) begin
            apply_async = 1'b0;
            repeat (6) @(negedge SYS_CLK);
            apply_async = 1'b1;
            repeat (6) @(negedge SYS_CLK);
        end
        apply_async = 1'b0;
        wait_done("pend_done_seen", db + 2, 3000);
        repeat (10) @(negedge SYS_CLK);
        check("pend_done_count", 32'(done_q.size() - db), 2);
        if (done_q.size() >= db + 2) check("pend_done_spacing", 32'(done_q[db+1] - done_q[db]), 652);
        check("pend_busy_runs", 32'(busy_q.size() - bb), 1);
        if (busy_q.size() > bb) check("pend_busy_len", 32'(busy_q[bb]), 1304);
        check_seq("pend_first", fb, 16'h2100, 16'hFFFF, 16'h4000, 16'hC000, 16'h2000);
        check_seq("pend_rerun", fb + 5, 16'h2100, 16'hFFFF, 16'h4000, 16'h1234, 16'h2000);

        // Reset during word 2, bit 7
        apply_async = 1'b1;
        n = 0;
        while (word_idx != 3'd2 && n < 1000) begin
            @(negedge SYS_CLK);
            n++;
        end
        check("rst_reach_word2", 32'(word_idx), 2);
        repeat (67) @(negedge SYS_CLK);
        check("rst_mid_fsync_low", 32'(dds_fsync), 0);
        #2;
        start_rst = 1'b1;
        #1;
        check("rst_async_fsync", 32'(dds_fsync), 1);
        check("rst_async_sclk", 32'(dds_sclk), 1);
        check("rst_async_sdata", 32'(dds_sdata), 0);
        check("rst_async_busy", 32'(busy), 0);
        check("rst_async_word_idx", 32'(word_idx), 0);
        repeat (3) @(negedge SYS_CLK);
        apply_async = 1'b0;
        start_rst = 1'b0;
        repeat (10) @(negedge SYS_CLK);

        // Fresh apply after reset gives a complete sequence
        fb = frame_q.size(); db = done_q.size(); bb = busy_q.size();
        apply_async = 1'b1;
        wait_done("post_rst_done_seen", db + 1, 1000);
        repeat (5) @(negedge SYS_CLK);
        apply_async = 1'b0;
        check_seq("post_rst", fb, 16'h2100, 16'hFFFF, 16'h4000, 16'h1234, 16'h2000);
        check("post_rst_done_count", 32'(done_q.size() - db), 1);
        if (busy_q.size() > bb) check("post_rst_busy_len", 32'(busy_q[bb]), 652);
        else check("post_rst_busy_runs", 32'(busy_q.size() - bb), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
